// File: rtl/ysyx_24080006_scoreboard_mp.sv
// In-order-commit scoreboard: entries allocated at issue, completed out of order by
// the write-back ports, retired from the head in issue order, with rs1/rs2 lookup.

module ysyx_24080006_scoreboard_mp_entry #(
  parameter int RegWidth  = 5,
  parameter int DataWidth = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 alloc_i,
  input  logic [3:0]           alloc_fu_i,
  input  logic [RegWidth-1:0]  alloc_rd_i,
  input  logic                 alloc_we_i,
  input  logic                 retire_i,
  input  logic                 wb_hit_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 valid_o,
  output logic                 done_o,
  output logic [3:0]           fu_o,
  output logic [RegWidth-1:0]  rd_o,
  output logic                 we_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_q, done_q, we_q;
  logic [3:0]           fu_q;
  logic [RegWidth-1:0]  rd_q;
  logic [DataWidth-1:0] data_q;

  // Allocation only targets a free slot, so it never collides with retire;
  // a write-back is honoured only if the slot was already live before this edge.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      fu_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (alloc_i) begin
      valid_q <= 1'b1;
      done_q  <= 1'b0;
      we_q    <= alloc_we_i;
      fu_q    <= alloc_fu_i;
      rd_q    <= alloc_rd_i;
      data_q  <= '0;
    end else if (retire_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (wb_hit_i && valid_q) begin
      done_q  <= 1'b1;
      data_q  <= wb_data_i;
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign fu_o    = fu_q;
  assign rd_o    = rd_q;
  assign we_o    = we_q;
  assign data_o  = data_q;

endmodule

module ysyx_24080006_scoreboard_mp #(
  parameter int Depth     = 4,
  parameter int NrWbPorts = 2,
  parameter int RegWidth  = 5,
  parameter int DataWidth = 32,
  parameter int IdxW      = $clog2(Depth)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [3:0]                     issue_fu_i,
  input  logic [RegWidth-1:0]            issue_rd_i,
  input  logic                           issue_we_i,
  output logic [IdxW-1:0]                issue_idx_o,
  input  logic [NrWbPorts-1:0]           wb_valid_i,
  input  logic [NrWbPorts*IdxW-1:0]      wb_idx_i,
  input  logic [NrWbPorts*DataWidth-1:0] wb_data_i,
  output logic                           commit_valid_o,
  input  logic                           commit_ready_i,
  output logic [3:0]                     commit_fu_o,
  output logic [RegWidth-1:0]            commit_rd_o,
  output logic                           commit_we_o,
  output logic [DataWidth-1:0]           commit_data_o,
  input  logic [RegWidth-1:0]            rs1_addr_i,
  input  logic [RegWidth-1:0]            rs2_addr_i,
  output logic                           rs1_busy_o,
  output logic                           rs2_busy_o,
  output logic                           rs1_fwd_valid_o,
  output logic                           rs2_fwd_valid_o,
  output logic [DataWidth-1:0]           rs1_fwd_data_o,
  output logic [DataWidth-1:0]           rs2_fwd_data_o,
  output logic [IdxW:0]                  count_o
);

  localparam logic [IdxW:0] FULL = (IdxW+1)'(Depth);

  logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IdxW:0]   count_q, count_d;
  logic            issue_fire, commit_fire;

  logic [Depth-1:0]                ent_valid, ent_done, ent_we, wb_hit;
  logic [Depth-1:0][3:0]           ent_fu;
  logic [Depth-1:0][RegWidth-1:0]  ent_rd;
  logic [Depth-1:0][DataWidth-1:0] ent_data, wb_sel;

  assign issue_ready_o = (count_q != FULL);
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign commit_fire   = commit_valid_o && commit_ready_i;
  assign issue_idx_o   = tail_q;
  assign count_o       = count_q;

  // Scanning ports low to high lets the highest-numbered port win a same-tag tie.
  always_comb begin
    wb_hit = '0;
    wb_sel = '0;
    for (int e = 0; e < Depth; e++) begin
      for (int p = 0; p < NrWbPorts; p++) begin
        if (wb_valid_i[p] && wb_idx_i[p*IdxW +: IdxW] == IdxW'(e)) begin
          wb_hit[e] = 1'b1;
          wb_sel[e] = wb_data_i[p*DataWidth +: DataWidth];
        end
      end
    end
  end

  for (genvar e = 0; e < Depth; e++) begin : g_ent
    ysyx_24080006_scoreboard_mp_entry #(
      .RegWidth  (RegWidth),
      .DataWidth (DataWidth)
    ) u_ent (
      .clock      (clock),
      .reset      (reset),
      .flush_i    (flush_i),
      .alloc_i    (issue_fire && tail_q == IdxW'(e)),
      .alloc_fu_i (issue_fu_i),
      .alloc_rd_i (issue_rd_i),
      .alloc_we_i (issue_we_i),
      .retire_i   (commit_fire && head_q == IdxW'(e)),
      .wb_hit_i   (wb_hit[e]),
      .wb_data_i  (wb_sel[e]),
      .valid_o    (ent_valid[e]),
      .done_o     (ent_done[e]),
      .fu_o       (ent_fu[e]),
      .rd_o       (ent_rd[e]),
      .we_o       (ent_we[e]),
      .data_o     (ent_data[e])
    );
  end

  assign commit_valid_o = ent_valid[head_q] && ent_done[head_q];
  assign commit_fu_o    = ent_fu[head_q];
  assign commit_rd_o    = ent_rd[head_q];
  assign commit_we_o    = ent_we[head_q];
  assign commit_data_o  = ent_data[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!flush_i) begin
      if (issue_fire)  tail_d = tail_q + 1'b1;
      if (commit_fire) head_d = head_q + 1'b1;
      count_d = count_q + (IdxW+1)'(issue_fire) - (IdxW+1)'(commit_fire);
    end else begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Operand lookup: youngest live writer wins, age measured from the head.
  logic [1:0][RegWidth-1:0]  rs_addr;
  logic [1:0]                rs_busy, rs_fv;
  logic [1:0][DataWidth-1:0] rs_fd;
  logic [1:0][IdxW-1:0]      best_age;
  logic [IdxW-1:0]           age;

  assign rs_addr = {rs2_addr_i, rs1_addr_i};

  always_comb begin
    rs_busy  = '0;
    rs_fv    = '0;
    rs_fd    = '0;
    best_age = '0;
    age      = '0;
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e < Depth; e++) begin
        age = IdxW'(e) - head_q;
        if (ent_valid[e] && ent_we[e] && rs_addr[r] != '0 && ent_rd[e] == rs_addr[r] &&
            (!rs_busy[r] || age > best_age[r])) begin
          rs_busy[r]  = 1'b1;
          rs_fv[r]    = ent_done[e];
          rs_fd[r]    = ent_data[e];
          best_age[r] = age;
        end
      end
    end
  end

  assign rs1_busy_o      = rs_busy[0];
  assign rs2_busy_o      = rs_busy[1];
  assign rs1_fwd_valid_o = rs_fv[0];
  assign rs2_fwd_valid_o = rs_fv[1];
  assign rs1_fwd_data_o  = rs_fd[0];
  assign rs2_fwd_data_o  = rs_fd[1];

endmodule

// File: tb/tb_ysyx_24080006_scoreboard_mp.sv
// Directed bench for the scoreboard: issue/WB/commit ordering, lookup, flush, wrap.

module tb_ysyx_24080006_scoreboard_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  issue_fu_i;
  logic [4:0]  issue_rd_i;
  logic        issue_we_i;
  logic [1:0]  issue_idx_o;
  logic [1:0]  wb_valid_i;
  logic [3:0]  wb_idx_i;
  logic [63:0] wb_data_i;
  logic        commit_valid_o;
  logic        commit_ready_i;
  logic [3:0]  commit_fu_o;
  logic [4:0]  commit_rd_o;
  logic        commit_we_o;
  logic [31:0] commit_data_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o;
  logic [31:0] rs1_fwd_data_o, rs2_fwd_data_o;
  logic [2:0]  count_o;

  int n_chk  = 0;
  int n_fail = 0;

  ysyx_24080006_scoreboard_mp dut (
    .clock           (clock),
    .reset           (reset),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_fu_i      (issue_fu_i),
    .issue_rd_i      (issue_rd_i),
    .issue_we_i      (issue_we_i),
    .issue_idx_o     (issue_idx_o),
    .wb_valid_i      (wb_valid_i),
    .wb_idx_i        (wb_idx_i),
    .wb_data_i       (wb_data_i),
    .commit_valid_o  (commit_valid_o),
    .commit_ready_i  (commit_ready_i),
    .commit_fu_o     (commit_fu_o),
    .commit_rd_o     (commit_rd_o),
    .commit_we_o     (commit_we_o),
    .commit_data_o   (commit_data_o),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_busy_o      (rs1_busy_o),
    .rs2_busy_o      (rs2_busy_o),
    .rs1_fwd_valid_o (rs1_fwd_valid_o),
    .rs2_fwd_valid_o (rs2_fwd_valid_o),
    .rs1_fwd_data_o  (rs1_fwd_data_o),
    .rs2_fwd_data_o  (rs2_fwd_data_o),
    .count_o         (count_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb1(input int port, input logic [1:0] idx, input logic [31:0] data);
    wb_valid_i = '0;
    wb_idx_i   = '0;
    wb_data_i  = '0;
    wb_valid_i[port] = 1'b1;
    wb_idx_i[port*2 +: 2] = idx;
    wb_data_i[port*32 +: 32] = data;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_fu_i = '0;
    issue_rd_i = '0; issue_we_i = 1'b0; wb_valid_i = '0; wb_idx_i = '0;
    wb_data_i = '0; commit_ready_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0;

    // reset
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_cvalid", commit_valid_o, 0);
    chk("rst_idx", issue_idx_o, 0);
    chk("rst_busy", rs1_busy_o, 0);
    chk("rst_cdata", commit_data_o, 0);

    // fill: rd=1..4, fu=0..3
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'b1; issue_we_i = 1'b1;
      issue_rd_i = 5'(i + 1); issue_fu_i = 4'(i);
      #1;
      chk("fill_idx", issue_idx_o, 64'(i));
      tick();
    end
    issue_rd_i = 5'd9;
    rs1_addr_i = 5'd3;
    #1;
    chk("full_count", count_o, 4);
    chk("full_ready", issue_ready_o, 0);
    chk("full_busy", rs1_busy_o, 1);
    chk("full_fv", rs1_fwd_valid_o, 0);
    tick();
    issue_valid_i = 1'b0;
    #1;
    chk("full_refuse_count", count_o, 4);
    chk("full_refuse_idx", issue_idx_o, 0);

    // out-of-order WB, in-order commit
    wb1(0, 2'd2, 32'hA);
    tick();
    wb_valid_i = '0;
    #1;
    chk("wb2_no_commit", commit_valid_o, 0);
    wb1(1, 2'd0, 32'hB);
    #1;
    chk("wb0_same_cycle", commit_valid_o, 0);
    tick();
    wb_valid_i = '0;
    #1;
    chk("c0_valid", commit_valid_o, 1);
    chk("c0_rd", commit_rd_o, 1);
    chk("c0_data", commit_data_o, 32'hB);
    chk("c0_fu", commit_fu_o, 0);
    chk("c0_we", commit_we_o, 1);
    commit_ready_i = 1'b1;
    tick();
    commit_ready_i = 1'b0;
    #1;
    chk("stall_valid", commit_valid_o, 0);
    chk("stall_count", count_o, 3);
    chk("stall_rd", commit_rd_o, 2);
    wb_valid_i = 2'b11; wb_idx_i = {2'd3, 2'd1}; wb_data_i = {32'hD, 32'hC};
    tick();
    wb_valid_i = '0;
    #1;
    chk("c1_valid", commit_valid_o, 1);
    chk("c1_data", commit_data_o, 32'hC);
    commit_ready_i = 1'b1;
    tick();
    chk("c2_rd", commit_rd_o, 3);
    chk("c2_data", commit_data_o, 32'hA);
    tick();
    chk("c3_rd", commit_rd_o, 4);
    chk("c3_data", commit_data_o, 32'hD);
    chk("c3_fu", commit_fu_o, 3);
    tick();
    commit_ready_i = 1'b0;
    #1;
    chk("drain_count", count_o, 0);
    chk("drain_valid", commit_valid_o, 0);
    chk("drain_ready", issue_ready_o, 1);

    // lookup: two writers of rd=5
    issue_valid_i = 1'b1; issue_rd_i = 5'd5; issue_fu_i = 4'd1; issue_we_i = 1'b1;
    #1;
    chk("r5a_idx", issue_idx_o, 0);
    tick();
    chk("r5b_idx", issue_idx_o, 1);
    tick();
    issue_valid_i = 1'b0;
    wb1(0, 2'd0, 32'h11);
    tick();
    wb_valid_i = '0;
    rs2_addr_i = 5'd5;
    #1;
    chk("lk_busy", rs2_busy_o, 1);
    chk("lk_young_notdone", rs2_fwd_valid_o, 0);
    chk("lk_cvalid", commit_valid_o, 1);
    chk("lk_cdata", commit_data_o, 32'h11);
    wb1(1, 2'd1, 32'h22);
    tick();
    wb_valid_i = '0;
    rs1_addr_i = 5'd0;
    #1;
    chk("lk2_busy", rs2_busy_o, 1);
    chk("lk2_fv", rs2_fwd_valid_o, 1);
    chk("lk2_data", rs2_fwd_data_o, 32'h22);
    chk("lk_x0", rs1_busy_o, 0);
    commit_ready_i = 1'b1;
    tick();
    chk("lk_c_data", commit_data_o, 32'h22);
    chk("lk_c_rd", commit_rd_o, 5);
    tick();
    commit_ready_i = 1'b0;
    #1;
    chk("lk_drain", count_o, 0);

    // same-tag WB on both ports; x0 writer; WB into freshly issued slot
    issue_valid_i = 1'b1; issue_rd_i = 5'd6;
    #1;
    chk("t2_idx", issue_idx_o, 2);
    tick();
    issue_rd_i = 5'd0;
    chk("t3_idx", issue_idx_o, 3);
    tick();
    issue_valid_i = 1'b0;
    wb_valid_i = 2'b11; wb_idx_i = {2'd2, 2'd2}; wb_data_i = {32'h2, 32'h1};
    tick();
    wb_valid_i = '0;
    rs1_addr_i = 5'd0;
    #1;
    chk("dual_valid", commit_valid_o, 1);
    chk("dual_data", commit_data_o, 32'h2);
    chk("dual_rd", commit_rd_o, 6);
    chk("x0_busy", rs1_busy_o, 0);
    commit_ready_i = 1'b1;
    tick();
    commit_ready_i = 1'b0;
    #1;
    chk("t3_wait", commit_valid_o, 0);
    chk("t3_count", count_o, 1);
    issue_valid_i = 1'b1; issue_rd_i = 5'd8;
    wb1(0, 2'd0, 32'h99);
    #1;
    chk("t0_idx", issue_idx_o, 0);
    tick();
    issue_valid_i = 1'b0;
    wb_valid_i = '0;
    rs1_addr_i = 5'd8;
    #1;
    chk("wb_inv_busy", rs1_busy_o, 1);
    chk("wb_inv_fv", rs1_fwd_valid_o, 0);
    wb1(0, 2'd1, 32'h55);
    tick();
    wb_valid_i = '0;
    #1;
    chk("wb_free_count", count_o, 2);
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    #1;
    chk("t1_idx", issue_idx_o, 1);
    tick();
    issue_rd_i = 5'd10;
    chk("t2b_idx", issue_idx_o, 2);
    tick();
    issue_valid_i = 1'b0;
    rs1_addr_i = 5'd9;
    #1;
    chk("refull_count", count_o, 4);
    chk("refull_fv", rs1_fwd_valid_o, 0);

    // flush while full, with WB and issue strobed
    flush_i = 1'b1; issue_valid_i = 1'b1; commit_ready_i = 1'b1;
    wb1(0, 2'd3, 32'h77);
    tick();
    flush_i = 1'b0; issue_valid_i = 1'b0; commit_ready_i = 1'b0; wb_valid_i = '0;
    rs1_addr_i = 5'd9;
    #1;
    chk("fl_count", count_o, 0);
    chk("fl_ready", issue_ready_o, 1);
    chk("fl_cvalid", commit_valid_o, 0);
    chk("fl_idx", issue_idx_o, 0);
    chk("fl_busy", rs1_busy_o, 0);

    // issue/commit pairs with tag wrap
    for (int k = 0; k < 6; k++) begin
      issue_valid_i = 1'b1; issue_rd_i = 5'(k + 1); issue_fu_i = 4'd2;
      if (k > 0) begin
        commit_ready_i = 1'b1;
        #1;
        chk("wr_cvalid", commit_valid_o, 1);
        chk("wr_cdata", commit_data_o, 64'(32'h100 + k - 1));
        chk("wr_crd", commit_rd_o, 64'(k));
      end else #1;
      chk("wr_idx", issue_idx_o, 64'(k % 4));
      tick();
      issue_valid_i = 1'b0; commit_ready_i = 1'b0;
      chk("wr_count", count_o, 1);
      wb1(0, 2'(k % 4), 32'h100 + 32'(k));
      tick();
      wb_valid_i = '0;
    end
    #1;
    chk("wr_last_valid", commit_valid_o, 1);
    chk("wr_last_data", commit_data_o, 32'h105);
    chk("wr_last_rd", commit_rd_o, 6);
    commit_ready_i = 1'b1;
    tick();
    commit_ready_i = 1'b0;
    chk("wr_end_count", count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
